// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the register-file write arbiter:
//   DEPTH / WIDTH / AW   register-file geometry (32 x 16, 5-bit address)
//   STARVE_LIMIT_DFLT    default number of blocked edges before S is forced
//   arb_state_t          arbiter FSM states
//   rf_wr_t              one register-file write (address + data)
//   starve_cnt_width()   width needed to count 0..limit
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEPTH = 32;
    localparam int WIDTH = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam int STARVE_LIMIT_DFLT = 4;

    typedef enum logic {
        NORMAL  = 1'b0,  // P has fixed priority
        FORCE_S = 1'b1   // S has been starved long enough; S wins
    } arb_state_t;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } rf_wr_t;

    // Counter must be able to hold the value 'limit' itself.
    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_starve_guard.sv
// -----------------------------------------------------------------------------
// starve_guard
//
// Starvation counter and two-state FSM for the secondary write source.
// Counts consecutive edges on which S is valid but loses to P. Once the count
// has reached STARVE_LIMIT and S is still blocked, the FSM moves to FORCE_S,
// which hands priority to S for the cycle in which it then transfers.
//
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous, active-high
//   s_valid  in  secondary request valid
//   p_valid  in  primary request valid
//   s_xfer   in  secondary transfer happens on this edge (s_valid && s_ready)
//   force_s  out 1 while in FORCE_S (S has priority)
// -----------------------------------------------------------------------------
module starve_guard
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic s_valid,
    input  logic p_valid,
    input  logic s_xfer,
    output logic force_s
);

    localparam int              CW    = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value; combinational blocks below use blocking (=).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= NORMAL;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_state_next = r_state;
        w_count_next = r_count;
        force_s      = 1'b0;

        case (r_state)
            NORMAL: begin
                if (!s_valid || s_xfer) begin
                    w_count_next = '0;
                end else if (p_valid && (r_count != LIMIT)) begin
                    // S blocked by P; saturate at the limit while waiting
                    // for the state change to take effect.
                    w_count_next = r_count + 1'b1;
                end
                // Only force if S is still losing on this edge; if it just
                // transferred there is nothing left to protect.
                if ((r_count == LIMIT) && s_valid && !s_xfer) begin
                    w_state_next = FORCE_S;
                end
            end

            FORCE_S: begin
                force_s = 1'b1;
                if (!s_valid || s_xfer) begin
                    w_state_next = NORMAL;
                    w_count_next = '0;
                end
            end

            default: begin
                w_state_next = NORMAL;
                w_count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between the primary pipeline
// writeback (P) and a secondary multi-cycle source (S). Each accepted write is
// held in a one-entry stage for one cycle; the stage drives the write port
// directly from registers and is forwarded to the two read ports.
// P has fixed priority except when the starvation guard forces S.
// Writes to register 0 complete the handshake but are never issued or
// forwarded, so register 0 stays zero.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   p_valid/p_ready/p_addr/p_data      primary write request (valid/ready)
//   s_valid/s_ready/s_addr/s_data      secondary write request (valid/ready)
//   rf_write_en/_address/_data         registered register-file write port
//   read_address_1/_2                  snooped register-file read addresses
//   fwd_hit_1/_2                       staged write matches read address
//   fwd_data_1/_2                      staged data on hit, else 0
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p_valid,
    output logic             p_ready,
    input  logic [AW-1:0]    p_addr,
    input  logic [WIDTH-1:0] p_data,

    input  logic             s_valid,
    output logic             s_ready,
    input  logic [AW-1:0]    s_addr,
    input  logic [WIDTH-1:0] s_data,

    output logic             rf_write_en,
    output logic [AW-1:0]    rf_write_address,
    output logic [WIDTH-1:0] rf_write_data,

    input  logic [AW-1:0]    read_address_1,
    input  logic [AW-1:0]    read_address_2,
    output logic             fwd_hit_1,
    output logic             fwd_hit_2,
    output logic [WIDTH-1:0] fwd_data_1,
    output logic [WIDTH-1:0] fwd_data_2
);

    logic   w_force_s;
    logic   w_p_xfer;
    logic   w_s_xfer;
    logic   w_any_xfer;
    rf_wr_t w_win;

    rf_wr_t r_stage;
    logic   r_stage_valid;

    // ------------------------------------------------------------------
    // Ready / grant. Depends only on FSM state and the valids, never on
    // address or data. The two transfers are mutually exclusive by
    // construction: the loser's ready is always low when both are valid.
    // ------------------------------------------------------------------
    assign p_ready    = w_force_s ? !s_valid : 1'b1;
    assign s_ready    = w_force_s ? 1'b1     : !p_valid;
    assign w_p_xfer   = p_valid && p_ready;
    assign w_s_xfer   = s_valid && s_ready;
    assign w_any_xfer = w_p_xfer || w_s_xfer;

    always_comb begin
        w_win = '{addr: s_addr, data: s_data};
        if (w_p_xfer) begin
            w_win = '{addr: p_addr, data: p_data};
        end
    end

    starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .p_valid (p_valid),
        .s_xfer  (w_s_xfer),
        .force_s (w_force_s)
    );

    // ------------------------------------------------------------------
    // Staging register. One write per cycle in, one write per cycle out,
    // so it never needs back-pressure. A transfer to address 0 loads the
    // stage but leaves it invalid, which suppresses both write and forward.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the stage data is reset too because it drives the write
            // port outputs directly; a storage array would not be reset.
            r_stage_valid <= 1'b0;
            r_stage       <= '0;
        end else begin
            r_stage_valid <= w_any_xfer && (w_win.addr != '0);
            if (w_any_xfer) begin
                r_stage <= w_win;
            end
        end
    end

    assign rf_write_en      = r_stage_valid;
    assign rf_write_address = r_stage.addr;
    assign rf_write_data    = r_stage.data;

    // ------------------------------------------------------------------
    // Forwarding: covers exactly the cycle the write is on the port, i.e.
    // the cycle before the register file itself can return the value.
    // ------------------------------------------------------------------
    assign fwd_hit_1  = r_stage_valid && (r_stage.addr == read_address_1);
    assign fwd_hit_2  = r_stage_valid && (r_stage.addr == read_address_2);
    assign fwd_data_1 = fwd_hit_1 ? r_stage.data : '0;
    assign fwd_data_2 = fwd_hit_2 ? r_stage.data : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter: reset state, a table of
// single-cycle vectors, hand-written reset and starvation sequences, and a
// randomized run against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             p_valid, p_ready, s_valid, s_ready;
    logic [AW-1:0]    p_addr, s_addr;
    logic [WIDTH-1:0] p_data, s_data;
    logic             rf_write_en;
    logic [AW-1:0]    rf_write_address;
    logic [WIDTH-1:0] rf_write_data;
    logic [AW-1:0]    read_address_1, read_address_2;
    logic             fwd_hit_1, fwd_hit_2;
    logic [WIDTH-1:0] fwd_data_1, fwd_data_2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .p_valid          (p_valid),
        .p_ready          (p_ready),
        .p_addr           (p_addr),
        .p_data           (p_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_addr           (s_addr),
        .s_data           (s_data),
        .rf_write_en      (rf_write_en),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .read_address_1   (read_address_1),
        .read_address_2   (read_address_2),
        .fwd_hit_1        (fwd_hit_1),
        .fwd_hit_2        (fwd_hit_2),
        .fwd_data_1       (fwd_data_1),
        .fwd_data_2       (fwd_data_2)
    );

    typedef struct {
        logic             pv;
        logic [AW-1:0]    pa;
        logic [WIDTH-1:0] pd;
        logic             sv;
        logic [AW-1:0]    sa;
        logic [WIDTH-1:0] sd;
        logic [AW-1:0]    ra1;
        logic [AW-1:0]    ra2;
        logic             x_prdy;
        logic             x_srdy;
        logic             x_en;
        logic             chk_ad;
        logic [AW-1:0]    x_addr;
        logic [WIDTH-1:0] x_data;
        logic             x_hit1;
        logic             x_hit2;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [AW-1:0] pa, input logic [WIDTH-1:0] pd,
                         input logic sv, input logic [AW-1:0] sa, input logic [WIDTH-1:0] sd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        read_address_1 = ra1; read_address_2 = ra2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    // Random-run state (behavioural model)
    bit               pp, sp, pxfer, sxfer, s_pri, exp_pr, exp_sr;
    logic [AW-1:0]    ra_pa, ra_sa, r1, r2;
    logic [WIDTH-1:0] ra_pd, ra_sd;
    int               streak;
    bit               m_valid;
    logic [AW-1:0]    m_addr;
    logic [WIDTH-1:0] m_data;

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1;
        idle();
        tick();
        tick();
        check("reset_en",      32'(rf_write_en), 32'd0);
        check("reset_addr",    32'(rf_write_address), 32'd0);
        check("reset_data",    32'(rf_write_data), 32'd0);
        check("reset_p_ready", 32'(p_ready), 32'd1);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        check("reset_hit1",    32'(fwd_hit_1), 32'd0);
        check("reset_hit2",    32'(fwd_hit_2), 32'd0);
        check("reset_fdata1",  32'(fwd_data_1), 32'd0);
        check("reset_fdata2",  32'(fwd_data_2), 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- table-driven vectors ----------------
        //            pv    pa     pd        sv    sa     sd        ra1    ra2    prdy  srdy  en    chk   xaddr  xdata     h1    h2
        tbl[0] = '{1'b1, 5'd1,  16'h0FA0, 1'b0, 5'd0,  16'h0000, 5'd1,  5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  16'h0FA0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'd2,  16'h1111, 1'b1, 5'd4,  16'h2222, 5'd4,  5'd1,  1'b1, 1'b0, 1'b1, 1'b1, 5'd2,  16'h1111, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd4,  16'h2222, 5'd4,  5'd4,  1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  16'h2222, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 5'd0,  16'hFFFF, 1'b0, 5'd0,  16'h0000, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  16'hFFFF, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0,  16'h0000, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd31, 16'hABCD, 5'd31, 5'd30, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 16'hABCD, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 5'd31, 16'h1234, 1'b1, 5'd31, 16'h5678, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 16'h1234, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd31, 16'h5678, 5'd31, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 16'h5678, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0,  16'h0000, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].sv, tbl[i].sa, tbl[i].sd,
                  tbl[i].ra1, tbl[i].ra2);
            #1;
            check($sformatf("tbl%0d_p_ready", i), 32'(p_ready), 32'(tbl[i].x_prdy));
            check($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].x_srdy));
            tick();
            check($sformatf("tbl%0d_en", i), 32'(rf_write_en), 32'(tbl[i].x_en));
            if (tbl[i].chk_ad) begin
                check($sformatf("tbl%0d_addr", i), 32'(rf_write_address), 32'(tbl[i].x_addr));
                check($sformatf("tbl%0d_data", i), 32'(rf_write_data), 32'(tbl[i].x_data));
            end
            check($sformatf("tbl%0d_hit1", i), 32'(fwd_hit_1), 32'(tbl[i].x_hit1));
            check($sformatf("tbl%0d_hit2", i), 32'(fwd_hit_2), 32'(tbl[i].x_hit2));
            check($sformatf("tbl%0d_fdata1", i), 32'(fwd_data_1),
                  tbl[i].x_hit1 ? 32'(tbl[i].x_data) : 32'd0);
            check($sformatf("tbl%0d_fdata2", i), 32'(fwd_data_2),
                  tbl[i].x_hit2 ? 32'(tbl[i].x_data) : 32'd0);
        end

        // ---------------- reset in the middle of a write ----------------
        drive(1'b1, 5'd3, 16'h0FA2, 1'b0, '0, '0, 5'd3, 5'd5);
        tick();
        check("rst_mid_en_before", 32'(rf_write_en), 32'd1);
        check("rst_mid_addr_before", 32'(rf_write_address), 32'd3);
        // Handshake offered while reset is high must be ignored.
        reset = 1'b1;
        drive(1'b1, 5'd5, 16'h5555, 1'b0, '0, '0, 5'd3, 5'd5);
        #1;
        check("rst_mid_p_ready", 32'(p_ready), 32'd1);
        tick();
        check("rst_mid_en_after", 32'(rf_write_en), 32'd0);
        check("rst_mid_hit1", 32'(fwd_hit_1), 32'd0);
        check("rst_mid_hit2", 32'(fwd_hit_2), 32'd0);
        reset = 1'b0;
        idle();
        read_address_1 = 5'd3;
        tick();
        check("rst_mid_en_idle", 32'(rf_write_en), 32'd0);
        check("rst_mid_hit1_idle", 32'(fwd_hit_1), 32'd0);

        // ---------------- starvation (limit 4) ----------------
        begin
            int  exp_a [9] = '{5, 6, 7, 8, 9, 7, 10, 11, 12};
            bit  exp_pr_s [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
            bit  exp_sr_s [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
            int  pi = 5;
            bit  s_pend = 1'b1;
            logic [WIDTH-1:0] exp_d;
            for (int c = 0; c < 9; c++) begin
                drive(1'b1, AW'(pi), WIDTH'(32'h0A00 + pi), s_pend, 5'd7, 16'h7777,
                      5'd7, AW'(pi));
                #1;
                check($sformatf("starve%0d_p_ready", c), 32'(p_ready), 32'(exp_pr_s[c]));
                check($sformatf("starve%0d_s_ready", c), 32'(s_ready), 32'(exp_sr_s[c]));
                tick();
                exp_d = (c == 5) ? 16'h7777 : WIDTH'(32'h0A00 + exp_a[c]);
                check($sformatf("starve%0d_en", c), 32'(rf_write_en), 32'd1);
                check($sformatf("starve%0d_addr", c), 32'(rf_write_address), 32'(exp_a[c]));
                check($sformatf("starve%0d_data", c), 32'(rf_write_data), 32'(exp_d));
                check($sformatf("starve%0d_hit1", c), 32'(fwd_hit_1), 32'(exp_a[c] == 7));
                if (exp_pr_s[c]) pi++;
                else             s_pend = 1'b0;
            end
            idle();
            tick();
        end

        // ---------------- randomized run vs. behavioural model ----------------
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        pp = 1'b0; sp = 1'b0; streak = 0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        ra_pa = '0; ra_sa = '0; ra_pd = '0; ra_sd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pp && ($urandom_range(0, 99) < 65)) begin
                pp    = 1'b1;
                ra_pa = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(0, DEPTH - 1));
                ra_pd = WIDTH'($urandom);
            end
            if (!sp && ($urandom_range(0, 99) < 40)) begin
                sp    = 1'b1;
                ra_sa = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(0, DEPTH - 1));
                ra_sd = WIDTH'($urandom);
            end
            r1 = $urandom_range(0, 1) ? m_addr : AW'($urandom_range(0, DEPTH - 1));
            r2 = $urandom_range(0, 1) ? m_addr : AW'($urandom_range(0, DEPTH - 1));
            drive(pp, ra_pa, ra_pd, sp, ra_sa, ra_sd, r1, r2);
            #1;

            // S gets priority once it has lost more than LIMIT edges in a row.
            s_pri  = (streak > LIMIT);
            exp_pr = s_pri ? !sp  : 1'b1;
            exp_sr = s_pri ? 1'b1 : !pp;
            check("rnd_p_ready", 32'(p_ready), 32'(exp_pr));
            check("rnd_s_ready", 32'(s_ready), 32'(exp_sr));
            check("rnd_hit1", 32'(fwd_hit_1), 32'(m_valid && (m_addr == r1)));
            check("rnd_hit2", 32'(fwd_hit_2), 32'(m_valid && (m_addr == r2)));
            check("rnd_fdata1", 32'(fwd_data_1), (m_valid && (m_addr == r1)) ? 32'(m_data) : 32'd0);
            check("rnd_fdata2", 32'(fwd_data_2), (m_valid && (m_addr == r2)) ? 32'(m_data) : 32'd0);

            pxfer  = pp && exp_pr;
            sxfer  = sp && exp_sr;
            streak = (sp && !sxfer) ? streak + 1 : 0;
            if (pxfer) begin
                m_valid = (ra_pa != '0); m_addr = ra_pa; m_data = ra_pd; pp = 1'b0;
            end else if (sxfer) begin
                m_valid = (ra_sa != '0); m_addr = ra_sa; m_data = ra_sd; sp = 1'b0;
            end else begin
                m_valid = 1'b0;
            end

            tick();
            check("rnd_en", 32'(rf_write_en), 32'(m_valid));
            if (m_valid) begin
                check("rnd_addr", 32'(rf_write_address), 32'(m_addr));
                check("rnd_data", 32'(rf_write_data), 32'(m_data));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
